// File: rtl/decode_exec_ctrl.sv
// RV32I ID-stage control: immediate generation, ALU control and branch resolution,
// with decode results registered toward EX under enable/stall control.
module decode_exec_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_ce,
    input  logic        i_stall,
    output logic        o_flush,
    output logic [31:0] o_branch_pc,
    output logic        o_stall,
    output logic [31:0] o_imm_data,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_pc,
    output logic [6:0]  o_opcode,
    output logic [2:0]  o_func3,
    output logic [3:0]  o_alu_ctrl,
    output logic        o_ce
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    logic [6:0]      w_opcode;
    logic [2:0]      w_func3;
    logic [XLEN-1:0] w_imm;
    logic [3:0]      w_alu_fn;
    logic [3:0]      w_alu_ctrl;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_taken;
    logic [XLEN-1:0] w_branch_pc;

    logic [XLEN-1:0] r_imm_data;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_pc;
    logic [6:0]      r_opcode;
    logic [2:0]      r_func3;
    logic [3:0]      r_alu_ctrl;
    logic            r_ce;

    assign w_opcode = i_instr[6:0];
    assign w_func3  = i_instr[14:12];

    // Immediate generation by instruction format
    always_comb begin
        w_imm = '0;
        case (w_opcode)
            OP_LOAD, OP_IALU, OP_JALR:
                w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            OP_STORE:
                w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            OP_BRANCH:
                w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {i_instr[31:12], 12'b0};
            OP_JAL:
                w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // func3 decode shared by R and I ALU ops; only R-type may pick SUB
    always_comb begin
        w_alu_fn = ALU_ADD;
        case (w_func3)
            3'b000:  w_alu_fn = (w_opcode == OP_RALU && i_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_fn = ALU_SLL;
            3'b010:  w_alu_fn = ALU_SLT;
            3'b011:  w_alu_fn = ALU_SLTU;
            3'b100:  w_alu_fn = ALU_XOR;
            3'b101:  w_alu_fn = i_instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_fn = ALU_OR;
            default: w_alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_opcode)
            OP_RALU, OP_IALU: w_alu_ctrl = w_alu_fn;
            OP_LUI:           w_alu_ctrl = ALU_PASSB;
            OP_BRANCH:        w_alu_ctrl = ALU_SUB;
            default:          w_alu_ctrl = ALU_ADD;
        endcase
    end

    assign w_eq  = (i_rs1_data == i_rs2_data);
    assign w_lt  = ($signed(i_rs1_data) < $signed(i_rs2_data));
    assign w_ltu = (i_rs1_data < i_rs2_data);

    // Branch/jump resolution; target is PC-relative except for JALR
    always_comb begin
        w_taken     = 1'b0;
        w_branch_pc = i_pc + w_imm;
        case (w_opcode)
            OP_BRANCH: begin
                case (w_func3)
                    3'b000:  w_taken = w_eq;
                    3'b001:  w_taken = ~w_eq;
                    3'b100:  w_taken = w_lt;
                    3'b101:  w_taken = ~w_lt;
                    3'b110:  w_taken = w_ltu;
                    3'b111:  w_taken = ~w_ltu;
                    default: w_taken = 1'b0;
                endcase
            end
            OP_JAL:  w_taken = 1'b1;
            OP_JALR: begin
                w_taken     = 1'b1;
                w_branch_pc = (i_rs1_data + w_imm) & ~XLEN'(1);
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign o_flush     = w_taken & i_ce & ~i_stall;
    assign o_branch_pc = w_branch_pc;
    assign o_stall     = i_stall;

    // ID/EX pipeline register; data holds unless a valid, unstalled instruction is present
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_imm_data <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_pc       <= '0;
            r_opcode   <= '0;
            r_func3    <= '0;
            r_alu_ctrl <= '0;
            r_ce       <= 1'b0;
        end else begin
            r_ce <= i_ce & ~i_stall;
            if (i_ce && !i_stall) begin
                r_imm_data <= w_imm;
                r_rs1_data <= i_rs1_data;
                r_rs2_data <= i_rs2_data;
                r_pc       <= i_pc;
                r_opcode   <= w_opcode;
                r_func3    <= w_func3;
                r_alu_ctrl <= w_alu_ctrl;
            end
        end
    end

    assign o_imm_data = r_imm_data;
    assign o_rs1_data = r_rs1_data;
    assign o_rs2_data = r_rs2_data;
    assign o_pc       = r_pc;
    assign o_opcode   = r_opcode;
    assign o_func3    = r_func3;
    assign o_alu_ctrl = r_alu_ctrl;
    assign o_ce       = r_ce;

endmodule

// File: tb/tb_decode_exec_ctrl.sv
// Bench for decode_exec_ctrl: directed vector table, stall/reset sequences, and
// randomized instructions checked against a behavioural decode model.
module tb_decode_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_instr, i_pc, i_rs1_data, i_rs2_data;
    logic        i_ce, i_stall;
    logic        o_flush, o_stall, o_ce;
    logic [31:0] o_branch_pc, o_imm_data, o_rs1_data, o_rs2_data, o_pc;
    logic [6:0]  o_opcode;
    logic [2:0]  o_func3;
    logic [3:0]  o_alu_ctrl;

    always #5 clk = ~clk;

    decode_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_instr(i_instr), .i_pc(i_pc),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_ce(i_ce), .i_stall(i_stall),
        .o_flush(o_flush), .o_branch_pc(o_branch_pc), .o_stall(o_stall),
        .o_imm_data(o_imm_data), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_pc(o_pc), .o_opcode(o_opcode), .o_func3(o_func3), .o_alu_ctrl(o_alu_ctrl),
        .o_ce(o_ce)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        ce;
        logic        stall;
        logic        rst_n;
        logic        flush;
        logic        chk_bpc;
        logic [31:0] bpc;
        logic [31:0] imm;
        logic [3:0]  alu;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // expected state of the registered outputs
    logic [31:0] e_imm, e_rs1, e_rs2, e_pc;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [3:0]  e_alu;
    logic        e_ce;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural decode: immediates built by arithmetic shifts of the raw word
    function automatic vec_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic ce, input logic st);
        vec_t r;
        logic [6:0] op;
        logic [2:0] f3;
        logic       tk;
        logic [3:0] fn [8];
        op = ins[6:0];
        f3 = ins[14:12];
        fn = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        r.instr = ins; r.pc = pc; r.rs1 = a; r.rs2 = b;
        r.ce = ce; r.stall = st; r.rst_n = 1'b1;
        case (op)
            7'h03, 7'h13, 7'h67: r.imm = 32'($signed(ins) >>> 20);
            7'h23: r.imm = 32'($signed({ins[31:25], ins[11:7], 20'b0}) >>> 20);
            7'h63: r.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19);
            7'h37, 7'h17: r.imm = ins & 32'hFFFF_F000;
            7'h6F: r.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11);
            default: r.imm = 32'd0;
        endcase
        case (op)
            7'h33, 7'h13: begin
                r.alu = fn[f3];
                if (f3 == 3'd0 && op == 7'h33 && ins[30]) r.alu = 4'd1;
                if (f3 == 3'd5 && ins[30]) r.alu = 4'd7;
            end
            7'h37:   r.alu = 4'd10;
            7'h63:   r.alu = 4'd1;
            default: r.alu = 4'd0;
        endcase
        tk = 1'b0;
        r.chk_bpc = 1'b1;
        r.bpc = pc + r.imm;
        case (op)
            7'h63: case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = ($signed(a) < $signed(b));
                3'd5: tk = ($signed(a) >= $signed(b));
                3'd6: tk = (a < b);
                3'd7: tk = (a >= b);
                default: tk = 1'b0;
            endcase
            7'h6F: tk = 1'b1;
            7'h67: begin tk = 1'b1; r.bpc = (a + r.imm) & 32'hFFFF_FFFE; end
            default: r.chk_bpc = 1'b0;
        endcase
        r.flush = tk & ce & ~st;
        return r;
    endfunction

    // Drive one vector, check combinational outputs, then the registered outputs after the edge
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        i_instr = v.instr; i_pc = v.pc; i_rs1_data = v.rs1; i_rs2_data = v.rs2;
        i_ce = v.ce; i_stall = v.stall; rst_n = v.rst_n;
        #1;
        chk({nm, ".flush"}, 32'(o_flush), 32'(v.flush));
        chk({nm, ".stall"}, 32'(o_stall), 32'(v.stall));
        if (v.chk_bpc) chk({nm, ".bpc"}, o_branch_pc, v.bpc);
        if (!v.rst_n) begin
            e_imm = '0; e_rs1 = '0; e_rs2 = '0; e_pc = '0;
            e_op = '0; e_f3 = '0; e_alu = '0; e_ce = 1'b0;
        end else begin
            e_ce = v.ce & ~v.stall;
            if (v.ce && !v.stall) begin
                e_imm = v.imm; e_rs1 = v.rs1; e_rs2 = v.rs2; e_pc = v.pc;
                e_op = v.instr[6:0]; e_f3 = v.instr[14:12]; e_alu = v.alu;
            end
        end
        @(posedge clk);
        #1;
        chk({nm, ".ce"},  32'(o_ce), 32'(e_ce));
        chk({nm, ".imm"}, o_imm_data, e_imm);
        chk({nm, ".alu"}, 32'(o_alu_ctrl), 32'(e_alu));
        chk({nm, ".op"},  32'(o_opcode), 32'(e_op));
        chk({nm, ".f3"},  32'(o_func3), 32'(e_f3));
        chk({nm, ".pc"},  o_pc, e_pc);
        chk({nm, ".rs1"}, o_rs1_data, e_rs1);
        chk({nm, ".rs2"}, o_rs2_data, e_rs2);
    endtask

    vec_t vt [19];

    initial begin
        //          instr          pc         rs1           rs2        ce    st    rst   flush chk   bpc            imm            alu
        vt[0]  = '{32'hFFB00093, 32'h0,     32'h0,        32'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0};
        vt[1]  = '{32'hFFB00093, 32'h4,     32'h0,        32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFB,  4'h0};
        vt[2]  = '{32'h00208463, 32'h100,   32'h7,        32'h7,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h108,      32'h8,         4'h1};
        vt[3]  = '{32'h00208463, 32'h100,   32'h7,        32'h8,     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h108,      32'h8,         4'h1};
        vt[4]  = '{32'h0020C463, 32'h200,   32'hFFFFFFFF, 32'h1,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h208,      32'h8,         4'h1};
        vt[5]  = '{32'h0020E463, 32'h200,   32'hFFFFFFFF, 32'h1,     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h208,      32'h8,         4'h1};
        vt[6]  = '{32'h00408067, 32'h300,   32'h1001,     32'h0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1004,     32'h4,         4'h0};
        vt[7]  = '{32'hFF1FF06F, 32'h20,    32'h0,        32'h0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10,       32'hFFFFFFF0,  4'h0};
        vt[8]  = '{32'h403100B3, 32'h24,    32'h11,       32'h22,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         4'h1};
        vt[9]  = '{32'h403150B3, 32'h28,    32'h33,       32'h44,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         4'h7};
        vt[10] = '{32'h123450B7, 32'h2C,    32'h0,        32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h12345000,  4'hA};
        vt[11] = '{32'hFE20AE23, 32'h30,    32'h55,       32'h66,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC,  4'h0};
        vt[12] = '{32'h40315093, 32'h34,    32'h0,        32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h403,       4'h7};
        vt[13] = '{32'hFFFFFFFF, 32'h38,    32'h1,        32'h2,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0};
        vt[14] = '{32'h00208463, 32'h100,   32'h9,        32'h9,     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h108,      32'h8,         4'h1};
        vt[15] = '{32'h00208463, 32'h100,   32'h9,        32'h9,     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h108,      32'h8,         4'h1};
        vt[16] = '{32'h00208463, 32'h100,   32'h9,        32'h9,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h108,      32'h8,         4'h1};
        vt[17] = '{32'hFFB00093, 32'h44,    32'hAB,       32'hCD,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFB,  4'h0};
        vt[18] = '{32'h00408067, 32'h48,    32'h1001,     32'h0,     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1004,     32'h4,         4'h0};

        rst_n = 1'b0; i_instr = '0; i_pc = '0; i_rs1_data = '0; i_rs2_data = '0;
        i_ce = 1'b0; i_stall = 1'b0;
        e_imm = '0; e_rs1 = '0; e_rs2 = '0; e_pc = '0;
        e_op = '0; e_f3 = '0; e_alu = '0; e_ce = 1'b0;

        for (int i = 0; i < 19; i++) apply(vt[i], $sformatf("vec%0d", i));

        // stall held over several cycles behind a captured instruction, then released
        apply(ref_model(32'h00A00093, 32'h500, 32'h1, 32'h2, 1'b1, 1'b0), "seq_cap");
        for (int i = 0; i < 3; i++)
            apply(ref_model(32'hFF1FF06F, 32'h600, 32'h0, 32'h0, 1'b1, 1'b1), "seq_stall");
        apply(ref_model(32'hFF1FF06F, 32'h600, 32'h0, 32'h0, 1'b1, 1'b0), "seq_rel");

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [6:0]  ops [10];
            logic [31:0] w, a, b, pc;
            logic        ce, st;
            vec_t        v;
            ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h00};
            w = $urandom();
            ops[9] = w[6:0];
            w[6:0] = ops[$urandom_range(0, 9)];
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
            pc = $urandom() & 32'hFFFF_FFFC;
            ce = ($urandom_range(0, 4) != 0);
            st = ($urandom_range(0, 4) == 0);
            v = ref_model(w, pc, a, b, ce, st);
            if ($urandom_range(0, 24) == 0) v.rst_n = 1'b0;
            apply(v, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
